// File: rtl/simple_target.sv
// simple_target: non-split byte-memory responder behind a target port.
// Completes every read and write locally. No split is ever requested.
// Writes acknowledge one cycle after commit. Reads respond READ_LATENCY
// cycles after address capture. The byte array is not touched by rst_n.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | ready for a new transaction
//   ST_WAIT_DATA | write address latched, waiting for data (with timeout)
//   ST_READ_WAIT | read address latched, latency down-counter running
//   ST_RESP      | ack (and read-data valid for reads) asserted this cycle
module simple_target #(
   parameter int unsigned INTERNAL_ADDR_BITS = 11,
   parameter int unsigned READ_LATENCY       = 2,
   parameter int unsigned DATA_TIMEOUT       = 16,
   parameter logic [7:0]  MEM_INIT_DATA      = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] target_addr_in,
   input  logic        target_addr_in_valid,
   input  logic [7:0]  target_data_in,
   input  logic        target_data_in_valid,
   input  logic        target_rw,
   output logic [7:0]  target_data_out,
   output logic        target_data_out_valid,
   output logic        target_ack,
   output logic        target_ready
);

   localparam int unsigned DEPTH        = 1 << INTERNAL_ADDR_BITS;
   localparam logic [7:0]  LAT_LOAD     = 8'(READ_LATENCY - 1);
   localparam logic [7:0]  TIMEOUT_LAST = 8'(DATA_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_READ_WAIT,
      ST_RESP
   } state_t;

   state_t                        state_q, state_d;
   logic [7:0]                    cnt_q, cnt_d;
   logic [INTERNAL_ADDR_BITS-1:0] addr_q, addr_d;
   logic [7:0]                    data_out_q, data_out_d;
   logic                          data_out_valid_q, data_out_valid_d;
   logic                          ack_q, ack_d;
   logic                          ready_q, ready_d;

   logic                          mem_we;
   logic [INTERNAL_ADDR_BITS-1:0] mem_waddr;
   logic [7:0]                    mem_wdata;

   // Byte storage: preloaded for simulation, deliberately outside the reset domain.
   logic [7:0] mem_q [DEPTH] = '{default: MEM_INIT_DATA};

   // Bus address bits above the local window are don't-care.
   logic [INTERNAL_ADDR_BITS-1:0] addr_in;
   logic                          unused_addr_bits;
   assign addr_in          = target_addr_in[INTERNAL_ADDR_BITS-1:0];
   assign unused_addr_bits = ^target_addr_in;

   // Next-state, counter, memory-write and registered-output decode.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      addr_d           = addr_q;
      data_out_d       = data_out_q;
      data_out_valid_d = 1'b0;
      ack_d            = 1'b0;
      mem_we           = 1'b0;
      mem_waddr        = addr_q;
      mem_wdata        = target_data_in;

      case (state_q)
         ST_IDLE: begin
            if (target_addr_in_valid) begin
               addr_d = addr_in;
               if (target_rw) begin
                  if (target_data_in_valid) begin
                     mem_we    = 1'b1;
                     mem_waddr = addr_in;
                     ack_d     = 1'b1;
                     state_d   = ST_RESP;
                  end else begin
                     cnt_d   = 8'd0;
                     state_d = ST_WAIT_DATA;
                  end
               end else begin
                  cnt_d   = LAT_LOAD;
                  state_d = ST_READ_WAIT;
               end
            end
         end
         ST_WAIT_DATA: begin
            // Data on the final timeout edge still wins over the abort.
            if (target_data_in_valid) begin
               mem_we  = 1'b1;
               ack_d   = 1'b1;
               cnt_d   = 8'd0;
               state_d = ST_RESP;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_READ_WAIT: begin
            if (cnt_q == 8'd0) begin
               data_out_d       = mem_q[addr_q];
               data_out_valid_d = 1'b1;
               ack_d            = 1'b1;
               state_d          = ST_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_DATA);
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= 8'd0;
         addr_q           <= '0;
         data_out_q       <= 8'h00;
         data_out_valid_q <= 1'b0;
         ack_q            <= 1'b0;
         ready_q          <= 1'b1;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         addr_q           <= addr_d;
         data_out_q       <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
         ack_q            <= ack_d;
         ready_q          <= ready_d;
      end
   end

   // Memory write port; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign target_data_out       = data_out_q;
   assign target_data_out_valid = data_out_valid_q;
   assign target_ack            = ack_q;
   assign target_ready          = ready_q;

endmodule

// File: tb/tb_simple_target.sv
// Self-checking bench for simple_target: directed vector table, hand-written
// corner sequences, randomized traffic against a byte-array reference model,
// and a read-latency sweep on two extra instances.
module tb_simple_target;

   localparam int T_OUT = 16;
   localparam int LAT   = 2;

   logic        clk;
   logic        rst_n;

   logic [15:0] addr;
   logic        addr_valid;
   logic [7:0]  din;
   logic        din_valid;
   logic        rw;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        ack;
   logic        ready;

   logic [15:0] s_addr;
   logic        s_addr_valid;
   logic [7:0]  s_din;
   logic        s_din_valid;
   logic        s_rw;
   logic [7:0]  s1_dout, s15_dout;
   logic        s1_valid, s15_valid;
   logic        s1_ack, s15_ack;
   logic        s1_ready, s15_ready;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] ref_mem [2048];

   typedef struct {
      bit          is_write;
      logic [15:0] a;
      logic [7:0]  d;
      int          dly;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs[$];

   simple_target dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .target_addr_in       (addr),
      .target_addr_in_valid (addr_valid),
      .target_data_in       (din),
      .target_data_in_valid (din_valid),
      .target_rw            (rw),
      .target_data_out      (dout),
      .target_data_out_valid(dout_valid),
      .target_ack           (ack),
      .target_ready         (ready)
   );

   simple_target #(.READ_LATENCY(1), .MEM_INIT_DATA(8'hA5)) dut_l1 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .target_addr_in       (s_addr),
      .target_addr_in_valid (s_addr_valid),
      .target_data_in       (s_din),
      .target_data_in_valid (s_din_valid),
      .target_rw            (s_rw),
      .target_data_out      (s1_dout),
      .target_data_out_valid(s1_valid),
      .target_ack           (s1_ack),
      .target_ready         (s1_ready)
   );

   simple_target #(.READ_LATENCY(15), .MEM_INIT_DATA(8'hA5)) dut_l15 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .target_addr_in       (s_addr),
      .target_addr_in_valid (s_addr_valid),
      .target_data_in       (s_din),
      .target_data_in_valid (s_din_valid),
      .target_rw            (s_rw),
      .target_data_out      (s15_dout),
      .target_data_out_valid(s15_valid),
      .target_ack           (s15_ack),
      .target_ready         (s15_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // dly=0: data with address. dly>0: data strobe dly cycles after capture;
   // beyond the timeout it lands in IDLE and must be ignored.
   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int dly);
      addr = a; rw = 1'b1; addr_valid = 1'b1; din = d; din_valid = (dly == 0);
      tick();
      addr_valid = 1'b0; din_valid = 1'b0; rw = 1'b0;
      if (dly == 0) begin
         check("wr_ack", ack, 1);
         check("wr_ready_busy", ready, 0);
         check("wr_no_valid", dout_valid, 0);
         ref_mem[a[10:0]] = d;
      end else begin
         check("wd_ready", ready, 1);
         check("wd_no_ack", ack, 0);
         for (int k = 1; k <= dly; k++) begin
            if (k == dly) begin
               din = d; din_valid = 1'b1;
            end
            tick();
            din_valid = 1'b0;
            if (k == dly && dly <= T_OUT) begin
               check("wd_ack", ack, 1);
               check("wd_ready_busy", ready, 0);
               check("wd_no_valid", dout_valid, 0);
               ref_mem[a[10:0]] = d;
            end else begin
               check("wd_wait_no_ack", ack, 0);
               check("wd_wait_ready", ready, 1);
            end
         end
      end
      tick();
      check("wr_ack_end", ack, 0);
      check("wr_ready_back", ready, 1);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [7:0] exp);
      addr = a; rw = 1'b0; addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      check("rd_ready_busy", ready, 0);
      check("rd_early_valid", dout_valid, 0);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) begin
            check("rd_wait_valid", dout_valid, 0);
            check("rd_wait_ack", ack, 0);
         end else begin
            check("rd_valid", dout_valid, 1);
            check("rd_ack", ack, 1);
            check("rd_data", dout, exp);
            check("rd_ready_resp", ready, 0);
         end
      end
      tick();
      check("rd_valid_end", dout_valid, 0);
      check("rd_ack_end", ack, 0);
      check("rd_ready_back", ready, 1);
      check("rd_data_hold", dout, exp);
   endtask

   task automatic sweep_read(input logic [15:0] a, input logic [7:0] exp);
      int first1, first15, cnt1, cnt15, ackmis;
      first1 = -1; first15 = -1; cnt1 = 0; cnt15 = 0; ackmis = 0;
      s_addr = a; s_rw = 1'b0; s_addr_valid = 1'b1;
      tick();
      s_addr_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (s1_valid === 1'b1) begin
            if (first1 < 0) first1 = k;
            cnt1++;
            check("sw_l1_data", s1_dout, exp);
         end
         if (s15_valid === 1'b1) begin
            if (first15 < 0) first15 = k;
            cnt15++;
            check("sw_l15_data", s15_dout, exp);
         end
         if (s1_ack !== s1_valid) ackmis++;
         if (s15_ack !== s15_valid) ackmis++;
      end
      check("sw_l1_first", 32'(first1), 32'd1);
      check("sw_l15_first", 32'(first15), 32'd15);
      check("sw_l1_width", 32'(cnt1), 32'd1);
      check("sw_l15_width", 32'(cnt15), 32'd1);
      check("sw_ack_with_valid", 32'(ackmis), 32'd0);
   endtask

   initial begin
      logic [15:0] ra;
      logic [7:0]  rd;
      int          kind;

      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;

      vecs.push_back('{1'b1, 16'h000A, 8'h5C, 0,  8'h00});
      vecs.push_back('{1'b0, 16'h000A, 8'h00, 0,  8'h5C});
      vecs.push_back('{1'b1, 16'h0123, 8'hA7, 3,  8'h00});
      vecs.push_back('{1'b0, 16'h0123, 8'h00, 0,  8'hA7});
      vecs.push_back('{1'b1, 16'h0050, 8'hEE, 18, 8'h00});
      vecs.push_back('{1'b0, 16'h0050, 8'h00, 0,  8'h00});
      vecs.push_back('{1'b1, 16'h0060, 8'h77, 16, 8'h00});
      vecs.push_back('{1'b0, 16'h0060, 8'h00, 0,  8'h77});
      vecs.push_back('{1'b1, 16'h0070, 8'h88, 17, 8'h00});
      vecs.push_back('{1'b0, 16'h0070, 8'h00, 0,  8'h00});
      vecs.push_back('{1'b1, 16'h0801, 8'h3E, 0,  8'h00});
      vecs.push_back('{1'b0, 16'h0001, 8'h00, 0,  8'h3E});
      vecs.push_back('{1'b0, 16'hF801, 8'h00, 0,  8'h3E});

      rst_n = 1'b0;
      addr = '0; addr_valid = 1'b0; din = '0; din_valid = 1'b0; rw = 1'b0;
      s_addr = '0; s_addr_valid = 1'b0; s_din = '0; s_din_valid = 1'b0; s_rw = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("rst_data_out", dout, 8'h00);
      check("rst_valid", dout_valid, 0);
      check("rst_ack", ack, 0);
      check("rst_ready", ready, 1);

      // Data strobe alone in IDLE is ignored.
      din = 8'h11; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      check("stray_data_ack", ack, 0);
      check("stray_data_ready", ready, 1);

      foreach (vecs[i]) begin
         if (vecs[i].is_write) do_write(vecs[i].a, vecs[i].d, vecs[i].dly);
         else                  do_read(vecs[i].a, vecs[i].exp);
      end

      // Strobes during READ_WAIT and RESP are dropped.
      addr = 16'h000A; rw = 1'b0; addr_valid = 1'b1;
      tick();
      addr = 16'h0001; rw = 1'b1; din = 8'h99; din_valid = 1'b1;
      tick();
      addr_valid = 1'b0; din_valid = 1'b0; rw = 1'b0;
      check("busy_wait_ack", ack, 0);
      tick();
      check("busy_rd_ack", ack, 1);
      check("busy_rd_valid", dout_valid, 1);
      check("busy_rd_data", dout, 8'h5C);
      addr = 16'h0001; rw = 1'b1; din = 8'h99; din_valid = 1'b1; addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0; din_valid = 1'b0; rw = 1'b0;
      check("busy_resp_ack", ack, 0);
      check("busy_resp_ready", ready, 1);
      tick();
      check("busy_after_ack", ack, 0);
      check("busy_after_ready", ready, 1);
      do_read(16'h0001, 8'h3E);

      // Address strobe during WAIT_DATA is ignored; the original write completes.
      addr = 16'h0200; rw = 1'b1; addr_valid = 1'b1;
      tick();
      addr = 16'h0300; rw = 1'b0;
      tick();
      addr_valid = 1'b0;
      check("wd_addr_ignored_ready", ready, 1);
      din = 8'h42; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      check("wd_addr_ignored_ack", ack, 1);
      ref_mem[11'h200] = 8'h42;
      tick();
      do_read(16'h0200, 8'h42);

      // Reset one cycle after read capture.
      addr = 16'h000A; rw = 1'b0; addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_data_out", dout, 8'h00);
      check("midrst_valid", dout_valid, 0);
      check("midrst_ack", ack, 0);
      check("midrst_ready", ready, 1);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("postrst_valid", dout_valid, 0);
         check("postrst_ack", ack, 0);
      end
      do_read(16'h000A, 8'h5C);

      // Randomized traffic against the reference byte array.
      for (int n = 0; n < 40; n++) begin
         ra   = (16'($urandom) & 16'hF800) | 16'($urandom_range(0, 15));
         rd   = 8'($urandom);
         kind = $urandom_range(0, 2);
         if (kind == 0)      do_write(ra, rd, 0);
         else if (kind == 1) do_write(ra, rd, $urandom_range(1, T_OUT + 3));
         else                do_read(ra, ref_mem[ra[10:0]]);
      end

      // Latency sweep on the READ_LATENCY=1 and 15 instances.
      s_addr = 16'h0123; s_rw = 1'b1; s_din = 8'h6D; s_din_valid = 1'b1; s_addr_valid = 1'b1;
      tick();
      s_addr_valid = 1'b0; s_din_valid = 1'b0; s_rw = 1'b0;
      check("sw_l1_wr_ack", s1_ack, 1);
      check("sw_l15_wr_ack", s15_ack, 1);
      tick();
      sweep_read(16'h0123, 8'h6D);
      sweep_read(16'h0005, 8'hA5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/simple_target.md
# simple_target

Non-split byte-memory target core: the responder at the far end of the serial bus that completes initiator reads and writes without ever requesting a split. Sits behind a target port, on the same core-side interface as the split target. It receives a deserialised address/data/direction and services the access from a local byte array. It returns an ACK, plus read data for reads, after a fixed, parameterised latency. Used as Slave 1/2 in system builds, wherever response time is short enough that no split is needed.

## Interface
- INTERNAL_ADDR_BITS, 11: width of local address; memory depth is 2^INTERNAL_ADDR_BITS bytes.
- READ_LATENCY, 2: cycles from read capture to response; legal range 1..15.
- DATA_TIMEOUT, 16: cycles a write waits for data before it is aborted; legal range 1..255.
- MEM_INIT_DATA, 8'h00: simulation-time initial value of every memory byte.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- target_addr_in  in  16  bus address; only bits [INTERNAL_ADDR_BITS-1:0] are used.
- target_addr_in_valid  in  1  address strobe; marks the start of a transaction.
- target_data_in  in  8  write data.
- target_data_in_valid  in  1  write data strobe.
- target_rw  in  1  direction; 1 = write, 0 = read. Sampled with the address strobe.
- target_data_out  out  8  read data.
- target_data_out_valid  out  1  read data strobe; one-cycle pulse.
- target_ack  out  1  transaction complete; one-cycle pulse.
- target_ready  out  1  high when a new transaction, or pending write data, can be accepted.

## Operation
- FSM states: IDLE, WAIT_DATA, READ_WAIT, RESP.
- **IDLE** (ready=1):
  - addr_valid and rw=1 and data_valid on the same edge: write mem[addr] at that edge, go to RESP.
  - addr_valid and rw=1 without data: latch addr, clear timeout counter, go to WAIT_DATA.
  - addr_valid and rw=0: latch addr, load latency counter, go to READ_WAIT.
  - data_valid without addr_valid: ignored.
- **WAIT_DATA** (ready=1):
  - data_valid: write mem[latched addr], go to RESP.
  - Otherwise increment the counter. When it reaches DATA_TIMEOUT, go to IDLE with no write and no ACK.
  - addr_valid in this state is ignored.
- **READ_WAIT** (ready=0): count down. On the edge that completes READ_LATENCY cycles after capture, register mem[latched addr] into data_out and go to RESP.
- **RESP** (ready=0): ack=1. For reads, data_out_valid=1 as well. Next edge returns to IDLE.
- Strobes arriving in READ_WAIT or RESP are dropped without effect.
- data_out holds the last read value until the next read completes.
- Memory is not cleared by rst_n. Its contents survive reset.

## Timing
- Reset values: target_data_out=8'h00, target_data_out_valid=0, target_ack=0, target_ready=1. State is IDLE and counters are 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Write: commit at edge E. target_ack is high for exactly the cycle following E. target_ready is 0 in that cycle and returns to 1 one cycle later.
- Read: address captured at edge E0. target_data_out_valid and target_ack rise together at edge E0+READ_LATENCY and are high for exactly one cycle. target_data_out is stable while valid is high.
- Back-to-back transactions: the earliest next capture is the edge after RESP ends, i.e. E+2 for writes.
- Read after write to the same address: returns the new data.
- Timeout: with no data for DATA_TIMEOUT cycles after capture, the FSM is back in IDLE at edge E0+DATA_TIMEOUT. data_valid on exactly that edge is still accepted.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately and the FSM returns to IDLE.
  - A pending write or read is discarded, with no ACK after release.
  - A write already committed before reset is retained.
- Address bits above INTERNAL_ADDR_BITS never affect behaviour. Addresses wrap modulo 2^INTERNAL_ADDR_BITS.

## Test plan
- **Write, data with address:** after reset, addr=16'h000A, rw=1, data=8'h5C in one cycle → target_ack high for 1 cycle at the next edge, target_data_out_valid stays 0. A following read of 16'h000A returns 8'h5C with ack and valid rising 2 cycles after capture (READ_LATENCY=2).
- **Write, data late:** addr=16'h0123, rw=1, then data=8'hA7 three cycles later → one ACK the cycle after the data edge. A read returns 8'hA7.
- **Write timeout:** addr=16'h0050, rw=1, no data for 16 cycles → no ACK, ready high again by cycle 16. A read of 16'h0050 returns MEM_INIT_DATA (8'h00).
- **Busy handling and address wrap:** during READ_WAIT, pulse addr_valid with rw=1 to 16'h0001 → ignored, exactly one ACK total. Separately, write 8'h3E to 16'h0801 and read 16'h0001 → 8'h3E (INTERNAL_ADDR_BITS=11).
- **Reset mid-read:** assert rst_n=0 one cycle after read capture → no valid or ACK ever appears, outputs at reset values. A previously written byte (8'h5C at 16'h000A) still reads back after reset.
- **Latency sweep:** with READ_LATENCY=1 and READ_LATENCY=15 → valid and ACK rise exactly 1 and 15 cycles after capture, each high for one cycle.
